rv32_branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the RV32 pipeline, sitting beside fetch and driven back from execute. It combines an untagged bimodal table of saturating counters (BHT) with a tagged branch target buffer (BTB). Its lookup output replaces the static `predicted_taken` currently fed to the branch PC mux and branch unit. It also keeps wrapping branch and mispredict counters for performance monitoring.

---
 rtl/rv32_branch_predictor.sv | 100 ++++++++++
 tb/tb_rv32_branch_predictor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_branch_predictor.sv
// Bimodal BHT + tagged BTB predictor: zero-latency combinational lookup, updates/flush land on the next edge.
// No handshake or backpressure: one update is accepted in every cycle that update_valid_in is high.
module rv32_branch_predictor #(
  parameter int ENTRIES      = 64,
  parameter int COUNTER_BITS = 2,
  parameter int TAG_BITS     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc_in,
  output logic        predicted_taken_out,
  output logic [31:0] predicted_pc_out,
  input  logic        update_valid_in,
  input  logic [31:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic [31:0] update_target_in,
  input  logic        update_mispredicted_in,
  input  logic        flush_in,
  output logic [31:0] branches_out,
  output logic [31:0] mispredicts_out
);
  localparam int IDX = $clog2(ENTRIES);
  localparam logic [COUNTER_BITS-1:0] CMAX = '1;
  localparam logic [COUNTER_BITS-1:0] WT   = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
  localparam logic [COUNTER_BITS-1:0] WNT  = WT - COUNTER_BITS'(1);

  logic [COUNTER_BITS-1:0] cnt_q [ENTRIES];
  logic [COUNTER_BITS-1:0] cnt_d [ENTRIES];
  logic [TAG_BITS-1:0]     tag_q [ENTRIES];
  logic [31:0]             tgt_q [ENTRIES];
  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [31:0]             br_q, br_d, mis_q, mis_d;

  logic [IDX-1:0]      lidx, uidx;
  logic [TAG_BITS-1:0] ltag, utag;
  logic                lhit, uhit, tbl_we;
  logic                unused_upd_pc;

  assign lidx = lookup_pc_in[IDX+1:2];
  assign ltag = lookup_pc_in[IDX+TAG_BITS+1:IDX+2];
  assign uidx = update_pc_in[IDX+1:2];
  assign utag = update_pc_in[IDX+TAG_BITS+1:IDX+2];
  assign unused_upd_pc = ^update_pc_in;

  assign lhit                = valid_q[lidx] && (tag_q[lidx] == ltag);
  assign uhit                = valid_q[uidx] && (tag_q[uidx] == utag);
  assign predicted_taken_out = lhit && cnt_q[lidx][COUNTER_BITS-1];
  assign predicted_pc_out    = predicted_taken_out ? tgt_q[lidx] : lookup_pc_in + 32'd4;
  assign branches_out        = br_q;
  assign mispredicts_out     = mis_q;

  // Target/tag only change on a taken update; a flush masks them through valid instead.
  assign tbl_we = update_valid_in && update_taken_in && !flush_in;

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    br_d    = br_q;
    mis_d   = mis_q;
    if (update_valid_in) begin
      br_d = br_q + 32'd1;
      if (update_mispredicted_in) mis_d = mis_q + 32'd1;
      if (update_taken_in) begin
        if (uhit) begin
          cnt_d[uidx] = (cnt_q[uidx] == CMAX) ? CMAX : cnt_q[uidx] + COUNTER_BITS'(1);
        end else begin
          valid_d[uidx] = 1'b1;
          cnt_d[uidx]   = WT;
        end
      end else begin
        cnt_d[uidx] = (cnt_q[uidx] == '0) ? '0 : cnt_q[uidx] - COUNTER_BITS'(1);
      end
    end
    if (flush_in) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) cnt_d[i] = WNT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      br_q    <= '0;
      mis_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else begin
      valid_q <= valid_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tag_q[uidx] <= utag;
      tgt_q[uidx] <= update_target_in;
    end
  end
endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Table-driven bench for rv32_branch_predictor with a scoreboard queue plus hand-written wrap/reset sequences.
module tb_rv32_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc_in;
  logic        predicted_taken_out;
  logic [31:0] predicted_pc_out;
  logic        update_valid_in;
  logic [31:0] update_pc_in;
  logic        update_taken_in;
  logic [31:0] update_target_in;
  logic        update_mispredicted_in;
  logic        flush_in;
  logic [31:0] branches_out;
  logic [31:0] mispredicts_out;

  rv32_branch_predictor dut (
    .clk(clk), .reset(reset),
    .lookup_pc_in(lookup_pc_in),
    .predicted_taken_out(predicted_taken_out),
    .predicted_pc_out(predicted_pc_out),
    .update_valid_in(update_valid_in),
    .update_pc_in(update_pc_in),
    .update_taken_in(update_taken_in),
    .update_target_in(update_target_in),
    .update_mispredicted_in(update_mispredicted_in),
    .flush_in(flush_in),
    .branches_out(branches_out),
    .mispredicts_out(mispredicts_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        um;
    logic        fl;
    logic        et;
    logic [31:0] epc;
    logic [31:0] ebr;
    logic [31:0] emis;
  } vec_t;

  typedef struct {
    int          id;
    logic        et;
    logic [31:0] epc;
    logic [31:0] ebr;
    logic [31:0] emis;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, want %h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utg, input logic um, input logic fl,
                              input logic et, input logic [31:0] epc, input logic [31:0] ebr,
                              input logic [31:0] emis);
    vec_t v;
    v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.um = um; v.fl = fl;
    v.et = et; v.epc = epc; v.ebr = ebr; v.emis = emis;
    return v;
  endfunction

  task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic um, input logic fl);
    update_valid_in = uv; update_pc_in = upc; update_taken_in = ut;
    update_target_in = utg; update_mispredicted_in = um; flush_in = fl;
  endtask

  initial begin
    // Expected outputs are for the lookup before the edge that commits the row's update.
    //           lpc          uv upc        ut utg       um fl  et epc          br  mis
    vt.push_back(mk(32'h100,  0, 32'h0,     0, 32'h0,   0, 0,  0, 32'h104,      0,  0)); // reset state
    vt.push_back(mk(32'h100,  1, 32'h100,   1, 32'h40,  1, 0,  0, 32'h104,      0,  0)); // allocate, WT
    vt.push_back(mk(32'h100,  1, 32'h100,   0, 32'h0,   1, 0,  1, 32'h40,       1,  1));
    vt.push_back(mk(32'h100,  1, 32'h100,   0, 32'h0,   0, 0,  0, 32'h104,      2,  2));
    vt.push_back(mk(32'h100,  1, 32'h100,   0, 32'h0,   0, 0,  0, 32'h104,      3,  2)); // floor at 0
    vt.push_back(mk(32'h100,  1, 32'h100,   1, 32'h40,  1, 0,  0, 32'h104,      4,  2));
    vt.push_back(mk(32'h100,  0, 32'h0,     0, 32'h0,   0, 0,  0, 32'h104,      5,  3)); // counter 1
    vt.push_back(mk(32'h100,  1, 32'h100,   1, 32'h80,  0, 0,  0, 32'h104,      5,  3)); // saturation run
    vt.push_back(mk(32'h100,  1, 32'h100,   1, 32'h80,  0, 0,  1, 32'h80,       6,  3));
    vt.push_back(mk(32'h100,  1, 32'h100,   1, 32'h80,  0, 0,  1, 32'h80,       7,  3));
    vt.push_back(mk(32'h100,  1, 32'h100,   1, 32'h80,  0, 0,  1, 32'h80,       8,  3));
    vt.push_back(mk(32'h100,  1, 32'h100,   1, 32'h80,  0, 0,  1, 32'h80,       9,  3));
    vt.push_back(mk(32'h100,  1, 32'h100,   0, 32'h0,   0, 0,  1, 32'h80,      10,  3)); // same-cycle hazard
    vt.push_back(mk(32'h100,  0, 32'h0,     0, 32'h0,   0, 0,  1, 32'h80,      11,  3)); // counter 2
    vt.push_back(mk(32'h200,  0, 32'h0,     0, 32'h0,   0, 0,  0, 32'h204,     11,  3)); // tag mismatch
    vt.push_back(mk(32'h10100,0, 32'h0,     0, 32'h0,   0, 0,  1, 32'h80,      11,  3)); // bit16 outside tag
    vt.push_back(mk(32'h200,  1, 32'h200,   1, 32'h300, 1, 0,  0, 32'h204,     11,  3)); // realloc alias
    vt.push_back(mk(32'h100,  0, 32'h0,     0, 32'h0,   0, 0,  0, 32'h104,     12,  4)); // old PC misses
    vt.push_back(mk(32'h200,  1, 32'h200,   0, 32'h0,   0, 0,  1, 32'h300,     12,  4));
    vt.push_back(mk(32'h200,  0, 32'h0,     0, 32'h0,   0, 0,  0, 32'h204,     13,  4)); // realloc gave WT
    vt.push_back(mk(32'h200,  1, 32'h200,   1, 32'h300, 0, 1,  0, 32'h204,     13,  4)); // flush + update
    vt.push_back(mk(32'h200,  0, 32'h0,     0, 32'h0,   0, 0,  0, 32'h204,     14,  4));
    vt.push_back(mk(32'h200,  1, 32'h200,   1, 32'h500, 0, 0,  0, 32'h204,     14,  4));
    vt.push_back(mk(32'h200,  1, 32'h200,   1, 32'h500, 0, 0,  1, 32'h500,     15,  4));
    vt.push_back(mk(32'h400,  1, 32'h400,   0, 32'h0,   1, 0,  0, 32'h404,     16,  4)); // NT miss: no alloc
    vt.push_back(mk(32'h200,  0, 32'h0,     0, 32'h0,   0, 0,  1, 32'h500,     17,  5));
    vt.push_back(mk(32'h400,  0, 32'h0,     0, 32'h0,   0, 0,  0, 32'h404,     17,  5));
    vt.push_back(mk(32'hFFFFFFFC,0,32'h0,   0, 32'h0,   0, 0,  0, 32'h0,       17,  5)); // PC wrap
    vt.push_back(mk(32'h104,  0, 32'h0,     0, 32'h0,   0, 0,  0, 32'h108,     17,  5));

    reset = 1'b1;
    lookup_pc_in = 32'h0;
    drive(0, 32'h0, 0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vt[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      lookup_pc_in = vt[i].lpc;
      drive(vt[i].uv, vt[i].upc, vt[i].ut, vt[i].utg, vt[i].um, vt[i].fl);
      e.id = i; e.et = vt[i].et; e.epc = vt[i].epc; e.ebr = vt[i].ebr; e.emis = vt[i].emis;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL scoreboard [%0d]: got empty queue, want entry", i);
      end else begin
        exp_t g;
        g = sb.pop_front();
        chk("taken", g.id, {31'b0, predicted_taken_out}, {31'b0, g.et});
        chk("pc", g.id, predicted_pc_out, g.epc);
        chk("branches", g.id, branches_out, g.ebr);
        chk("mispredicts", g.id, mispredicts_out, g.emis);
      end
    end

    // Perf counter wrap, preloaded just below 2^32.
    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 32'h0, 0, 0);
    @(negedge clk);
    force dut.br_q  = 32'hFFFF_FFFF;
    force dut.mis_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_q;
    release dut.mis_q;
    #1;
    chk("preload_br", 100, branches_out, 32'hFFFF_FFFF);
    drive(1, 32'h104, 1, 32'h900, 1, 0);
    @(posedge clk);
    #1;
    chk("wrap_br", 101, branches_out, 32'h0);
    chk("wrap_mis_pre", 101, mispredicts_out, 32'hFFFF_FFFF);
    drive(1, 32'h104, 1, 32'h900, 1, 0);
    @(posedge clk);
    #1;
    chk("wrap_br2", 102, branches_out, 32'h1);
    chk("wrap_mis", 102, mispredicts_out, 32'h0);
    drive(1, 32'h104, 1, 32'h900, 0, 0);
    @(posedge clk);
    #1;
    chk("no_mis_br", 103, branches_out, 32'h2);
    chk("no_mis_mis", 103, mispredicts_out, 32'h0);

    // Asynchronous reset in the middle of an update stream.
    lookup_pc_in = 32'h200;
    drive(1, 32'h100, 1, 32'h40, 1, 0);
    @(negedge clk);
    chk("pre_rst_taken", 104, {31'b0, predicted_taken_out}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_br", 105, branches_out, 32'h0);
    chk("rst_mis", 105, mispredicts_out, 32'h0);
    chk("rst_taken", 105, {31'b0, predicted_taken_out}, 32'h0);
    chk("rst_pc", 105, predicted_pc_out, 32'h204);
    @(posedge clk);
    #1;
    chk("rst_hold_br", 106, branches_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 32'h0, 0, 32'h0, 0, 0);
    lookup_pc_in = 32'h100;
    #1;
    chk("post_rst_taken", 107, {31'b0, predicted_taken_out}, 32'h0);
    chk("post_rst_pc", 107, predicted_pc_out, 32'h104);
    @(posedge clk);
    #1;
    chk("post_rst_br", 108, branches_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
